// File: rtl/uart_pixel_packer_pkg.sv
// Shared types and constants for the UART pixel packer.
package uart_pixel_packer_pkg;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         RGB565_W          = 16;

endpackage

// File: rtl/pixel_skid_reg.sv
// One-entry pending pixel register between the byte assembler and the FIFO.
// A new pixel is accepted if the slot is empty or is being drained this cycle;
// otherwise the new pixel is dropped and the held one is kept.
module pixel_skid_reg
  import uart_pixel_packer_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [RGB565_W-1:0] load_data,
  input  logic                fifo_full,
  output logic                pend_valid,
  output logic [RGB565_W-1:0] pend_data,
  output logic                wr_en,
  output logic                drop
);

  logic accept;

  assign wr_en  = pend_valid & ~fifo_full;
  assign accept = load & (~pend_valid | wr_en);
  assign drop   = load & pend_valid & fifo_full;

  // Pending slot: reload wins over drain, drain empties the slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else if (accept) begin
      pend_valid <= 1'b1;
      pend_data  <= load_data;
    end else if (wr_en) begin
      pend_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_pixel_packer.sv
// Assembles RGB565 pixels from a UART byte stream framed by a sync byte,
// with per-frame pixel counting, inter-byte timeout and sticky error flags.
module uart_pixel_packer
  import uart_pixel_packer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         FRAME_PIXELS   = 65536,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic [RGB565_W-1:0] fifo_data,
  output logic                frame_start,
  output logic                frame_done,
  output logic                busy,
  output logic                overflow_err,
  output logic                timeout_err,
  input  logic                clear_err
);

  localparam int CNT_W  = $clog2(FRAME_PIXELS);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  state_t              state, state_n;
  logic [CNT_W-1:0]    pix_cnt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [7:0]          hi_byte;
  logic                timeout_hit;
  logic                start_c, done_c, load_c;
  logic                pend_valid, drop;

  // The last idle clock of the allowed window aborts the frame.
  assign timeout_hit = (state != ST_HUNT) && !rx_valid && (idle_cnt == IDLE_LAST);
  assign busy        = (state != ST_HUNT);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_HUNT;
    else          state <= state_n;
  end

  // Next-state and per-cycle strobes.
  always_comb begin
    state_n = state;
    start_c = 1'b0;
    done_c  = 1'b0;
    load_c  = 1'b0;
    case (state)
      ST_HUNT: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_n = ST_HI;
          start_c = 1'b1;
        end
      end
      ST_HI: begin
        if (timeout_hit)   state_n = ST_HUNT;
        else if (rx_valid) state_n = ST_LO;
      end
      ST_LO: begin
        if (timeout_hit) begin
          state_n = ST_HUNT;
        end else if (rx_valid) begin
          load_c  = 1'b1;
          done_c  = (pix_cnt == LAST_PIX);
          state_n = done_c ? ST_HUNT : ST_HI;
        end
      end
      default: state_n = ST_HUNT;
    endcase
  end

  // Pixel counter, high-byte latch and frame pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt     <= '0;
      hi_byte     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_start <= start_c;
      frame_done  <= done_c;
      if (start_c || done_c)                  pix_cnt <= '0;
      else if (load_c)                        pix_cnt <= pix_cnt + CNT_W'(1);
      if (state == ST_HI && rx_valid)         hi_byte <= rx_data;
    end
  end

  // Idle counter: runs only between bytes inside a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                        idle_cnt <= '0;
    else if (state == ST_HUNT || rx_valid || timeout_hit) idle_cnt <= '0;
    else                                                 idle_cnt <= idle_cnt + IDLE_W'(1);
  end

  // Sticky errors; clear beats a simultaneous set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else if (clear_err) begin
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (drop)        overflow_err <= 1'b1;
      if (timeout_hit) timeout_err  <= 1'b1;
    end
  end

  pixel_skid_reg u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load_c),
    .load_data  ({hi_byte, rx_data}),
    .fifo_full  (fifo_full),
    .pend_valid (pend_valid),
    .pend_data  (fifo_data),
    .wr_en      (fifo_wr_en),
    .drop       (drop)
  );

endmodule
